bsg_fifo_to_mmio_regs: RTL
==========================

BSG_FIFO_TO_MMIO_REGS -- requirements
Module: bsg_fifo_to_mmio_regs

Interface
REQ-001 SHALL have parameter addr_width_p, default 32, the command address width.
REQ-002 SHALL have parameter data_width_p, default 32, the data, register and response width (minimum 8).
REQ-003 SHALL have parameter num_regs_p, default 8, the number of control registers (range 1..16).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port v_i, input, 1 bit: a write command is valid.
REQ-007 SHALL have port addr_i, input, addr_width_p bits: the command byte address.
REQ-008 SHALL have port data_i, input, data_width_p bits: the command write data.
REQ-009 SHALL have port yumi_o, output, 1 bit: the command is consumed this cycle.
REQ-010 SHALL have port v_o, output, 1 bit: a response word is valid.
REQ-011 SHALL have port data_o, output, data_width_p bits: the response word.
REQ-012 SHALL have port ready_i, input, 1 bit: the response sink accepts a word.
REQ-013 SHALL have port regs_o, output, num_regs_p*data_width_p bits: the flattened registers, with register k at bits [k*data_width_p +: data_width_p].
REQ-014 SHALL have port status_i, input, data_width_p bits: the external status word.
REQ-015 SHALL have port doorbell_o, output, 1 bit: a one-cycle doorbell pulse.
REQ-016 SHALL have port doorbell_data_o, output, data_width_p bits: the doorbell payload.

Function
REQ-017 SHALL decode only addr_i[7:0]; upper address bits are ignored.
REQ-018 SHALL implement this address map:
- 0x00 is CMD.
- 0x04 is DOORBELL.
- 0x40+4*k is register k, for k < num_regs_p.
- Every other offset, and any offset with addr_i[1:0] != 0, is an error.
REQ-019 SHALL run a 2-state FSM, IDLE and RESP; reset enters IDLE.
REQ-020 In IDLE, SHALL drive yumi_o = v_i, consuming any command in the same cycle it is presented.
REQ-021 In RESP, SHALL hold yumi_o = 0, stalling all commands (including register writes) until the response is accepted.
REQ-022 On a consumed register-k write, SHALL load register k with data_i; the new value is visible on regs_o in the next cycle.
REQ-023 On a consumed DOORBELL write, SHALL assert doorbell_o for exactly the next cycle and register data_i onto doorbell_data_o, which holds until the next doorbell.
REQ-024 On a consumed CMD write, SHALL capture the response word and move to RESP; v_o rises in the next cycle (1-cycle latency).
REQ-025 SHALL select the CMD response word by this priority:
- data_i[5]=1: the error counter, zero-extended.
- else data_i[4]=1: status_i as sampled in the consume cycle.
- else data_i[3:0] < num_regs_p: register data_i[3:0].
- else: data_width_p'(32'hDEADBEEF), and the error counter increments.
REQ-026 In RESP, SHALL hold v_o=1 with data_o stable until ready_i=1, then return to IDLE in the next cycle with v_o=0.
REQ-027 Given REQ-021, SHALL accept at most one command every 2 cycles when consecutive commands are CMDs and ready_i is held at 1.
REQ-028 On a consumed error-address write, SHALL drop the write and increment the error counter.
REQ-029 The error counter SHALL be 8 bits and saturate at 255.
REQ-030 Reading the error counter through CMD SHALL NOT clear it.
REQ-031 SHALL drive data_o = 0 whenever v_o = 0.
REQ-032 SHALL place v_o and data_o directly from flops, with no combinational path from ready_i or v_i.
REQ-033 SHALL NOT make yumi_o depend on ready_i.

Reset
REQ-034 On reset_n_i = 0, SHALL immediately (asynchronously) set the following, regardless of clock:
- FSM to IDLE.
- v_o = 0 and data_o = 0.
- All registers, regs_o, doorbell_o, doorbell_data_o and the error counter to 0.
REQ-035 Reset asserted while in RESP SHALL discard the pending response; no response is emitted after reset release.
REQ-036 While reset_n_i = 0, SHALL hold yumi_o = 0.
REQ-037 After reset_n_i deasserts, the first command SHALL be accepted no earlier than the first rising clock edge.

Verification
REQ-038 Directed scenario: write 0x44 with 0x1234_5678, then CMD with data 0x1 and ready_i=1 -> yumi_o pulses twice; data_o = 0x1234_5678 with v_o=1 for 1 cycle; regs_o[63:32] = 0x1234_5678.
REQ-039 Directed scenario: CMD with data 0x10, status_i = 0xA5A5_0000, ready_i=0 for 5 cycles then 1 -> v_o=1 and data_o = 0xA5A5_0000 for 6 cycles; a queued register write is not consumed until after acceptance.
REQ-040 Directed scenario: writes to 0x08, 0x41 and 0x60 (num_regs_p=8), then CMD with data 0x20 -> response 0x0000_0003, and no register changes.
REQ-041 Directed scenario: 300 error writes, then CMD with data 0x20 -> response 0x0000_00FF; CMD with data 0xF -> 0xDEAD_BEEF, and the counter stays 255.
REQ-042 Directed scenario: DOORBELL write with 0xCAFE -> doorbell_o high for exactly 1 cycle; doorbell_data_o = 0xCAFE, held afterwards.
REQ-043 Directed scenario: CMD consumed, then reset_n_i pulsed low mid-RESP -> v_o drops immediately; regs_o = 0; no response after release; the next CMD with data 0x0 returns 0.

Source files
------------

// File: rtl/bsg_fifo_to_mmio_regs.sv
// Write-command FIFO to MMIO register file: register writes, doorbell pulses,
// and CMD reads that return one response word through a valid/ready port.
module bsg_fifo_to_mmio_regs #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int num_regs_p   = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             v_i,
  input  logic [addr_width_p-1:0]          addr_i,
  input  logic [data_width_p-1:0]          data_i,
  output logic                             yumi_o,
  output logic                             v_o,
  output logic [data_width_p-1:0]          data_o,
  input  logic                             ready_i,
  output logic [num_regs_p*data_width_p-1:0] regs_o,
  input  logic [data_width_p-1:0]          status_i,
  output logic                             doorbell_o,
  output logic [data_width_p-1:0]          doorbell_data_o
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e state_reg, state_next;

  logic [7:0]  offset;
  logic [3:0]  reg_idx;
  logic        is_cmd, is_db, is_reg, is_err;
  logic        consume;

  logic [15:0][data_width_p-1:0] regs_pad;
  logic [data_width_p-1:0] resp_word;
  logic                    resp_miss;

  logic [7:0]              err_cnt_reg, err_cnt_next;
  logic                    err_inc;
  logic                    v_reg;
  logic [data_width_p-1:0] data_reg;
  logic                    doorbell_reg;
  logic [data_width_p-1:0] doorbell_data_reg;

  // Only the low address byte is decoded; the rest is intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i;

  assign offset  = addr_i[7:0];
  assign reg_idx = offset[5:2];

  always_comb begin
    is_cmd = (offset == 8'h00);
    is_db  = (offset == 8'h04);
    is_reg = (offset[7:6] == 2'b01) && (offset[1:0] == 2'b00)
             && ({1'b0, reg_idx} < 5'(num_regs_p));
    is_err = !(is_cmd || is_db || is_reg);
  end

  // FSM: state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (consume && is_cmd) state_next = RESP;
      RESP:    if (ready_i)           state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs; yumi is gated by reset so nothing is taken while held in reset
  always_comb begin
    yumi_o = reset_n_i && v_i && (state_reg == IDLE);
  end

  assign consume = yumi_o;

  always_comb begin
    resp_miss = 1'b0;
    if (data_i[5])
      resp_word = data_width_p'(err_cnt_reg);
    else if (data_i[4])
      resp_word = status_i;
    else if ({1'b0, data_i[3:0]} < 5'(num_regs_p))
      resp_word = regs_pad[data_i[3:0]];
    else begin
      resp_word = data_width_p'(32'hDEADBEEF);
      resp_miss = 1'b1;
    end
  end

  assign err_inc      = consume && (is_err || (is_cmd && resp_miss));
  assign err_cnt_next = (err_inc && (err_cnt_reg != 8'hFF)) ? err_cnt_reg + 8'd1 : err_cnt_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_cnt_reg       <= '0;
      v_reg             <= 1'b0;
      data_reg          <= '0;
      doorbell_reg      <= 1'b0;
      doorbell_data_reg <= '0;
    end else begin
      err_cnt_reg  <= err_cnt_next;
      v_reg        <= (state_next == RESP);
      doorbell_reg <= consume && is_db;
      if (consume && is_db)
        doorbell_data_reg <= data_i;
      if (consume && is_cmd)
        data_reg <= resp_word;
      else if ((state_reg == RESP) && ready_i)
        data_reg <= '0;
    end
  end

  assign v_o             = v_reg;
  assign data_o          = data_reg;
  assign doorbell_o      = doorbell_reg;
  assign doorbell_data_o = doorbell_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < num_regs_p; gi++) begin : g_reg
      logic [data_width_p-1:0] value_reg;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
          value_reg <= '0;
        else if (consume && is_reg && (reg_idx == 4'(gi)))
          value_reg <= data_i;
      end

      assign regs_o[gi*data_width_p +: data_width_p] = value_reg;
      assign regs_pad[gi] = value_reg;
    end

    // Pad the readback mux to 16 entries so any 4-bit selector is in range.
    for (gi = num_regs_p; gi < 16; gi++) begin : g_pad
      assign regs_pad[gi] = '0;
    end
  endgenerate

endmodule
